// File: rtl/avfcl_pkg.sv
// Shared types and defaults for the AVF importance-metadata queue.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package avfcl_pkg;

    localparam int MD_W          = 5;    // metadata word width
    localparam int IMPQ_DEPTH    = 128;  // queue entries, power of two
    localparam int IMPQ_PUSH_MAX = 6;    // words decode may push per cycle
    localparam int IMPQ_POP_MAX  = 4;    // commit width

    typedef logic [MD_W-1:0] md_word_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        RESYNC = 2'd2
    } mqc_state_e;

endpackage

// File: rtl/mqc_ram.sv
// DEPTH x W register array, WR_LANES write ports with per-lane enable, RD_LANES async read ports.
// Latency: write visible on reads the cycle after the write edge; reads are combinational.
// Backpressure: none; callers guarantee lanes written in one cycle target distinct entries.
//
// Ports: clk; wr_en/wr_addr/wr_data lane k at [k*AW +: AW] / [k*W +: W];
//        rd_addr/rd_data lane k at [k*AW +: AW] / [k*W +: W]. Contents are not reset.
module mqc_ram #(
    parameter int DEPTH    = 128,
    parameter int W        = 5,
    parameter int WR_LANES = 6,
    parameter int RD_LANES = 4,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic [WR_LANES-1:0]    wr_en,
    input  logic [WR_LANES*AW-1:0] wr_addr,
    input  logic [WR_LANES*W-1:0]  wr_data,
    input  logic [RD_LANES*AW-1:0] rd_addr,
    output logic [RD_LANES*W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int k = 0; k < WR_LANES; k++) begin
            if (wr_en[k]) begin
                mem[wr_addr[k*AW +: AW]] <= wr_data[k*W +: W];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < RD_LANES; k++) begin
            rd_data[k*W +: W] = mem[rd_addr[k*AW +: AW]];
        end
    end

endmodule

// File: rtl/metadata_queue_ctrl.sv
// Circular importance-metadata queue: multi-word push from decode, per-instruction pop at retire.
// Latency: pushed words appear on head_* the cycle after acceptance; pops take effect next cycle.
// Backpressure: push_ready low when fewer than PUSH_MAX slots free or not in RUN.
//
// Ports: clk, reset (sync, active-high); push_valid/push_count/push_words/push_bb_start in,
//        push_ready out; pop_count, flush in; head_words/head_valid window of POP_MAX words;
//        occupancy, resync state flag, sticky overflow_err/underflow_err.
module metadata_queue_ctrl
    import avfcl_pkg::*;
#(
    parameter int DEPTH    = IMPQ_DEPTH,
    parameter int PUSH_MAX = IMPQ_PUSH_MAX,
    parameter int POP_MAX  = IMPQ_POP_MAX,
    parameter int W        = MD_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push_valid,
    input  logic [$clog2(PUSH_MAX+1)-1:0]  push_count,
    input  logic [PUSH_MAX*W-1:0]          push_words,
    input  logic                           push_bb_start,
    output logic                           push_ready,
    input  logic [$clog2(POP_MAX+1)-1:0]   pop_count,
    input  logic                           flush,
    output logic [POP_MAX*W-1:0]           head_words,
    output logic [POP_MAX-1:0]             head_valid,
    output logic [$clog2(DEPTH):0]         occupancy,
    output logic                           resync,
    output logic                           overflow_err,
    output logic                           underflow_err
);

    localparam int AW    = $clog2(DEPTH);
    localparam int OCC_W = AW + 1;
    localparam int PCW   = $clog2(PUSH_MAX+1);

    mqc_state_e       state_q;
    logic [AW-1:0]    head_q, tail_q, head_nxt;
    logic [OCC_W-1:0] occ_q, space, pc_w, pop_w, pushed, popped;
    logic             ovf_q, unf_q;
    logic             in_run, in_rs, run_acc, rs_acc, push_acc, ovf_evt, unf_evt;

    logic [PUSH_MAX-1:0]    wr_en;
    logic [PUSH_MAX*AW-1:0] wr_addr;
    logic [POP_MAX*AW-1:0]  rd_addr;

    // Free slots; occupancy has the extra bit so DEPTH (full) is representable.
    assign space = OCC_W'(DEPTH) - occ_q;

    always_comb begin
        pc_w    = OCC_W'(push_count);
        pop_w   = OCC_W'(pop_count);
        in_run  = (state_q == RUN);
        in_rs   = (state_q == RESYNC);
        run_acc = push_valid && in_run && (pc_w <= space);
        // Occupancy is zero in RESYNC; a zero-length bb push is a no-op and must not leave RESYNC.
        rs_acc  = push_valid && in_rs && push_bb_start
                  && (pc_w <= OCC_W'(DEPTH)) && (push_count != '0);
        ovf_evt = !flush && push_valid && in_run && (pc_w > space);
        push_acc = !flush && (run_acc || rs_acc);
        pushed  = push_acc ? pc_w : '0;
        // Pops compare against occupancy before this cycle's push, so fresh words never retire.
        if (in_rs) begin
            popped = '0;
        end else if (pop_w > occ_q) begin
            popped = occ_q;
        end else begin
            popped = pop_w;
        end
        unf_evt  = !in_rs && (pop_w > occ_q);
        head_nxt = head_q + popped[AW-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            head_q <= head_nxt;
            if (unf_evt) unf_q <= 1'b1;
            if (ovf_evt) ovf_q <= 1'b1;
            if (flush) begin
                state_q <= FLUSH;
                tail_q  <= head_nxt;
                occ_q   <= '0;
            end else if (ovf_evt) begin
                // Drop the whole push and realign tail to head; consumer sees no valid words.
                state_q <= RESYNC;
                tail_q  <= head_nxt;
                occ_q   <= '0;
            end else begin
                tail_q <= tail_q + pushed[AW-1:0];
                occ_q  <= occ_q + pushed - popped;
                if (state_q == FLUSH || rs_acc) begin
                    state_q <= RUN;
                end
            end
        end
    end

    for (genvar k = 0; k < PUSH_MAX; k++) begin : g_wr
        assign wr_en[k]             = push_acc && (PCW'(k) < push_count);
        assign wr_addr[k*AW +: AW]  = tail_q + AW'(k);
    end

    for (genvar k = 0; k < POP_MAX; k++) begin : g_rd
        assign rd_addr[k*AW +: AW] = head_q + AW'(k);
        assign head_valid[k]       = (OCC_W'(k) < occ_q) && !in_rs;
    end

    mqc_ram #(
        .DEPTH    (DEPTH),
        .W        (W),
        .WR_LANES (PUSH_MAX),
        .RD_LANES (POP_MAX),
        .AW       (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (push_words),
        .rd_addr (rd_addr),
        .rd_data (head_words)
    );

    assign push_ready    = in_run && (space >= OCC_W'(PUSH_MAX));
    assign occupancy     = occ_q;
    assign resync        = in_rs;
    assign overflow_err  = ovf_q;
    assign underflow_err = unf_q;

endmodule

// File: tb/tb_metadata_queue_ctrl.sv
module tb_metadata_queue_ctrl;
    import avfcl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        push_valid;
    logic [2:0]  push_count;
    logic [29:0] push_words;
    logic        push_bb_start;
    logic        push_ready;
    logic [2:0]  pop_count;
    logic        flush;
    logic [19:0] head_words;
    logic [3:0]  head_valid;
    logic [7:0]  occupancy;
    logic        resync;
    logic        overflow_err;
    logic        underflow_err;

    always #5 clk = ~clk;

    metadata_queue_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .push_valid    (push_valid),
        .push_count    (push_count),
        .push_words    (push_words),
        .push_bb_start (push_bb_start),
        .push_ready    (push_ready),
        .pop_count     (pop_count),
        .flush         (flush),
        .head_words    (head_words),
        .head_valid    (head_valid),
        .occupancy     (occupancy),
        .resync        (resync),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    typedef struct packed {
        logic [7:0]  occ;
        logic        rdy;
        logic [3:0]  hv;
        logic [19:0] hw;
        logic        rs;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t  exp_q[$];
    string nm_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    function automatic logic [29:0] w6(int a, int b, int c, int d, int e, int f);
        return {5'(f), 5'(e), 5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    function automatic logic [19:0] w4(int a, int b, int c, int d);
        return {5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    task automatic cmp(input string nm, input string fld, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, expv);
        end
    endtask

    // Monitor: compares the post-edge state whenever an expectation is pending.
    always @(negedge clk) begin
        exp_t     e;
        string    nm;
        md_word_t wa, we;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            cmp(nm, "occupancy",     int'(occupancy),     int'(e.occ));
            cmp(nm, "push_ready",    int'(push_ready),    int'(e.rdy));
            cmp(nm, "head_valid",    int'(head_valid),    int'(e.hv));
            cmp(nm, "resync",        int'(resync),        int'(e.rs));
            cmp(nm, "overflow_err",  int'(overflow_err),  int'(e.ovf));
            cmp(nm, "underflow_err", int'(underflow_err), int'(e.unf));
            for (int k = 0; k < 4; k++) begin
                if (e.hv[k]) begin
                    wa = head_words[k*5 +: 5];
                    we = e.hw[k*5 +: 5];
                    cmp(nm, $sformatf("head_word%0d", k), int'(wa), int'(we));
                end
            end
        end
    end

    task automatic chk(input string nm, input int occ, input logic rdy, input logic [3:0] hv,
                       input logic [19:0] hw, input logic rs, input logic ovf, input logic unf);
        exp_t e;
        e.occ = 8'(occ); e.rdy = rdy; e.hv = hv; e.hw = hw;
        e.rs = rs; e.ovf = ovf; e.unf = unf;
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    // One clock of stimulus; inputs return to idle just after the edge.
    task automatic cyc(input logic pv, input int pc, input logic [29:0] wv, input logic bb,
                       input int popc, input logic fl);
        push_valid    = pv;
        push_count    = 3'(pc);
        push_words    = wv;
        push_bb_start = bb;
        pop_count     = 3'(popc);
        flush         = fl;
        @(posedge clk);
        #1;
        push_valid = 1'b0; push_count = '0; push_words = '0;
        push_bb_start = 1'b0; pop_count = '0; flush = 1'b0;
    endtask

    initial begin
        logic [29:0] wv;
        reset = 1'b1;
        push_valid = 1'b0; push_count = '0; push_words = '0;
        push_bb_start = 1'b0; pop_count = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset", 0, 1, 4'b0000, '0, 0, 0, 0);

        cyc(1, 6, w6(1,2,3,4,5,6), 0, 0, 0);
        chk("push6", 6, 1, 4'b1111, w4(1,2,3,4), 0, 0, 0);
        cyc(1, 0, w6(31,31,31,31,31,31), 0, 0, 0);
        chk("push0_noop", 6, 1, 4'b1111, w4(1,2,3,4), 0, 0, 0);
        cyc(1, 3, w6(7,8,9,0,0,0), 0, 4, 0);
        chk("pop4_push3", 5, 1, 4'b1111, w4(5,6,7,8), 0, 0, 0);
        cyc(0, 0, '0, 0, 4, 0);
        chk("pop4_to1", 1, 1, 4'b0001, w4(9,0,0,0), 0, 0, 0);

        // Fill from tail=9: fill word n carries value (n+1) mod 32.
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < 6; k++) wv[k*5 +: 5] = 5'((i*6 + k + 1) & 31);
            cyc(1, 6, wv, 0, 0, 0);
        end
        chk("fill121", 121, 1, 4'b1111, w4(9,1,2,3), 0, 0, 0);
        cyc(1, 2, w6(121 & 31, 122 & 31, 0, 0, 0, 0), 0, 0, 0);
        chk("fill123", 123, 0, 4'b1111, w4(9,1,2,3), 0, 0, 0);
        cyc(1, 6, w6(1,1,1,1,1,1), 0, 0, 0);
        chk("overflow", 0, 0, 4'b0000, '0, 1, 1, 0);
        cyc(1, 2, w6(3,3,0,0,0,0), 0, 3, 0);
        chk("resync_drop", 0, 0, 4'b0000, '0, 1, 1, 0);
        cyc(1, 2, w6(10,11,0,0,0,0), 1, 0, 0);
        chk("resync_bb", 2, 1, 4'b0011, w4(10,11,0,0), 0, 1, 0);

        // Walk head to 124 so the next push straddles the wrap.
        cyc(0, 0, '0, 0, 2, 0);
        chk("drain", 0, 1, 4'b0000, '0, 0, 1, 0);
        for (int i = 0; i < 19; i++) cyc(1, 6, '0, 0, 0, 0);
        for (int i = 0; i < 28; i++) cyc(0, 0, '0, 0, 4, 0);
        cyc(0, 0, '0, 0, 2, 0);
        chk("head124", 0, 1, 4'b0000, '0, 0, 1, 0);
        cyc(1, 6, w6(21,22,23,24,25,26), 0, 0, 0);
        chk("wrap_push", 6, 1, 4'b1111, w4(21,22,23,24), 0, 1, 0);
        cyc(0, 0, '0, 0, 3, 0);
        chk("wrap_pop3", 3, 1, 4'b0111, w4(24,25,26,0), 0, 1, 0);
        cyc(0, 0, '0, 0, 1, 0);
        chk("wrap_pop1", 2, 1, 4'b0011, w4(25,26,0,0), 0, 1, 0);

        // Flush with a concurrent push and pop.
        cyc(1, 6, w6(1,2,3,4,5,6), 0, 0, 0);
        cyc(1, 2, w6(7,8,0,0,0,0), 0, 0, 0);
        chk("occ10", 10, 1, 4'b1111, w4(25,26,1,2), 0, 1, 0);
        cyc(1, 4, w6(30,30,30,30,0,0), 0, 2, 1);
        chk("flush", 0, 0, 4'b0000, '0, 0, 1, 0);
        cyc(0, 0, '0, 0, 0, 0);
        chk("post_flush", 0, 1, 4'b0000, '0, 0, 1, 0);
        cyc(0, 0, '0, 0, 0, 1);
        chk("flush_a", 0, 0, 4'b0000, '0, 0, 1, 0);
        cyc(0, 0, '0, 0, 0, 1);
        chk("flush_ext", 0, 0, 4'b0000, '0, 0, 1, 0);
        cyc(0, 0, '0, 0, 0, 0);
        chk("flush_end", 0, 1, 4'b0000, '0, 0, 1, 0);
        cyc(1, 1, w6(9,0,0,0,0,0), 0, 0, 0);
        chk("push_after_flush", 1, 1, 4'b0001, w4(9,0,0,0), 0, 1, 0);

        // Underflow: pop 3 with one word held.
        cyc(0, 0, '0, 0, 3, 0);
        chk("underflow", 0, 1, 4'b0000, '0, 0, 1, 1);
        cyc(1, 1, w6(17,0,0,0,0,0), 0, 0, 0);
        chk("unf_sticky", 1, 1, 4'b0001, w4(17,0,0,0), 0, 1, 1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: pending %0d expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
